// File: rtl/bist_sram_model.sv
// rtl/bist_sram_model.sv - single-port SRAM responder with shift-loaded fault injection
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   i_addr, i_data            word address, write data
//   i_cs/i_we/i_re/i_oe       chip select, write, read, output enable
//   i_odd_bwe, i_even_bwe     write enables for odd / even bit indices
//   o_q                       read data (one-cycle latency, zero when output disabled)
//   i_shift_mode, si, so      fault-descriptor shift chain control and serial in/out
module bist_sram_model #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 7,
    parameter int NUM_FAULTS = 2,
    parameter int BIT_W      = $clog2(DATA_W),
    parameter int DESC_W     = 3 + ADDR_W + BIT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_cs,
    input  logic              i_we,
    input  logic              i_re,
    input  logic              i_oe,
    input  logic              i_odd_bwe,
    input  logic              i_even_bwe,
    output logic [DATA_W-1:0] o_q,
    input  logic              i_shift_mode,
    input  logic              si,
    output logic              so
);
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int CHAIN_W = NUM_FAULTS * DESC_W;

    // Array contents survive reset; zero power-up value for FPGA and simulation.
    logic [DATA_W-1:0]  mem_q [DEPTH] = '{default: '0};

    logic [CHAIN_W-1:0] chain_q, chain_d;
    logic [DATA_W-1:0]  rd_q, rd_d;
    logic               oe_q, oe_d;

    logic [DATA_W-1:0]       stored;
    logic [DATA_W-1:0]       hit;
    logic [DATA_W-1:0][1:0]  ftype;
    logic [DATA_W-1:0]       bwe;
    logic [DATA_W-1:0]       wdata_f;
    logic [DATA_W-1:0]       rdata_f;
    logic                    do_write;
    logic                    do_read;

    assign stored   = mem_q[i_addr];
    assign do_write = ~i_shift_mode & i_cs & i_we;
    assign do_read  = ~i_shift_mode & i_cs & i_re & ~i_we;

    // Per-bit fault lookup for the addressed word. Scanning descriptors in
    // ascending order lets the highest-index match overwrite earlier ones.
    // A bit field >= DATA_W never equals any loop index, so it is inert.
    always_comb begin
        hit   = '0;
        ftype = '0;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            for (int b = 0; b < DATA_W; b++) begin
                if (chain_q[i*DESC_W + DESC_W - 1] &&
                    chain_q[i*DESC_W + BIT_W +: ADDR_W] == i_addr &&
                    chain_q[i*DESC_W +: BIT_W] == BIT_W'(b)) begin
                    hit[b]   = 1'b1;
                    ftype[b] = chain_q[i*DESC_W + BIT_W + ADDR_W +: 2];
                end
            end
        end
    end

    // Fault-filtered write and read data. Transition faults depend on the
    // stored value and the incoming value; stuck-at faults force both paths.
    always_comb begin
        bwe     = '0;
        wdata_f = i_data;
        rdata_f = stored;
        for (int b = 0; b < DATA_W; b++) begin
            bwe[b] = (b % 2 == 1) ? i_odd_bwe : i_even_bwe;
            if (hit[b]) begin
                case (ftype[b])
                    2'b00: begin
                        wdata_f[b] = 1'b0;
                        rdata_f[b] = 1'b0;
                    end
                    2'b01: begin
                        wdata_f[b] = 1'b1;
                        rdata_f[b] = 1'b1;
                    end
                    2'b10: if (i_data[b] && !stored[b]) wdata_f[b] = 1'b0;
                    default: if (!i_data[b] && stored[b]) wdata_f[b] = 1'b1;
                endcase
            end
        end
    end

    // Array write is gated by rstn so a reset edge aborts the access.
    always_ff @(posedge clk) begin
        if (rstn && do_write) begin
            mem_q[i_addr] <= (stored & ~bwe) | (wdata_f & bwe);
        end
    end

    always_comb begin
        chain_d = chain_q;
        rd_d    = rd_q;
        oe_d    = oe_q;
        if (i_shift_mode) begin
            chain_d = {chain_q[CHAIN_W-2:0], si};
        end else if (do_read) begin
            rd_d = rdata_f;
            oe_d = i_oe;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            chain_q <= '0;
            rd_q    <= '0;
            oe_q    <= 1'b0;
        end else begin
            chain_q <= chain_d;
            rd_q    <= rd_d;
            oe_q    <= oe_d;
        end
    end

    assign o_q = oe_q ? rd_q : '0;
    assign so  = chain_q[CHAIN_W-1];

endmodule

// File: tb/tb_bist_sram_model.sv
// tb/tb_bist_sram_model.sv - self-checking bench for bist_sram_model
module tb_bist_sram_model;
    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] i_addr;
    logic [6:0] i_data;
    logic       i_cs, i_we, i_re, i_oe, i_odd_bwe, i_even_bwe;
    logic [6:0] o_q;
    logic       i_shift_mode, si;
    logic       so;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    bist_sram_model dut (
        .clk(clk), .rstn(rstn), .i_addr(i_addr), .i_data(i_data),
        .i_cs(i_cs), .i_we(i_we), .i_re(i_re), .i_oe(i_oe),
        .i_odd_bwe(i_odd_bwe), .i_even_bwe(i_even_bwe), .o_q(o_q),
        .i_shift_mode(i_shift_mode), .si(si), .so(so)
    );

    always #5 clk = ~clk;

    // Reference model: plain word array, chain as a 20-bit vector.
    logic [6:0]  mem_m [16];
    logic [19:0] chain_m;
    logic [6:0]  rq_m;
    logic        roe_m;

    // Highest-index enabled descriptor matching (a,b) wins; -1 = no fault.
    function automatic int fault_of(input logic [19:0] c, input int a, input int b);
        for (int i = 1; i >= 0; i--) begin
            int dsc;
            dsc = int'((c >> (i * 10)) & 20'h3FF);
            if (((dsc >> 9) & 1) == 1 && ((dsc >> 3) & 15) == a && (dsc & 7) == b)
                return (dsc >> 7) & 3;
        end
        return -1;
    endfunction

    task automatic model_step();
        int a;
        logic [6:0] w, r;
        a = int'(i_addr);
        if (i_shift_mode) begin
            chain_m = {chain_m[18:0], si};
        end else if (i_cs && i_we) begin
            w = mem_m[a];
            for (int b = 0; b < 7; b++) begin
                if ((b % 2 == 1) ? i_odd_bwe : i_even_bwe) begin
                    logic v;
                    logic s;
                    int f;
                    v = i_data[b];
                    s = mem_m[a][b];
                    f = fault_of(chain_m, a, b);
                    if (f == 0) v = 1'b0;
                    else if (f == 1) v = 1'b1;
                    else if (f == 2 && v && !s) v = 1'b0;
                    else if (f == 3 && !v && s) v = 1'b1;
                    w[b] = v;
                end
            end
            mem_m[a] = w;
        end else if (i_cs && i_re) begin
            r = mem_m[a];
            for (int b = 0; b < 7; b++) begin
                int f;
                f = fault_of(chain_m, a, b);
                if (f == 0) r[b] = 1'b0;
                else if (f == 1) r[b] = 1'b1;
            end
            rq_m  = r;
            roe_m = i_oe;
        end
    endtask

    always @(negedge rstn) begin
        chain_m = '0;
        rq_m    = '0;
        roe_m   = 1'b0;
    end

    always @(posedge clk) if (rstn === 1'b1) model_step();

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_o_q", o_q, roe_m ? rq_m : 7'h00);
            chk("model_so", {6'b0, so}, {6'b0, chain_m[19]});
        end
    end

    task automatic acc(input logic cs, we, re, oe, odd, even,
                       input logic [3:0] a, input logic [6:0] d);
        i_shift_mode = 1'b0;
        i_cs = cs; i_we = we; i_re = re; i_oe = oe;
        i_odd_bwe = odd; i_even_bwe = even;
        i_addr = a; i_data = d;
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [6:0] d);
        acc(1, 1, 0, 1, 1, 1, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        acc(1, 0, 1, 1, 0, 0, a, 7'h00);
    endtask

    task automatic shift_in(input logic [19:0] v);
        i_cs = 1'b0;
        for (int k = 19; k >= 0; k--) begin
            i_shift_mode = 1'b1;
            si = v[k];
            @(negedge clk);
        end
        i_shift_mode = 1'b0;
        si = 1'b0;
    endtask

    function automatic logic [9:0] mk(input logic en, input logic [1:0] t,
                                      input logic [3:0] a, input logic [2:0] b);
        return {en, t, a, b};
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) mem_m[i] = '0;
        chain_m = '0; rq_m = '0; roe_m = 1'b0;
        rstn = 1'b0; si = 1'b0; i_shift_mode = 1'b0;
        i_cs = 0; i_we = 0; i_re = 0; i_oe = 0; i_odd_bwe = 0; i_even_bwe = 0;
        i_addr = '0; i_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_o_q", o_q, 7'h00);
        chk("reset_so", {6'b0, so}, 7'h00);
        rstn = 1'b1;
        chk_en = 1'b1;

        wr(4'd3, 7'h55);
        chk("pre_read_o_q", o_q, 7'h00);
        rd(4'd3);
        chk("read_55", o_q, 7'h55);

        acc(1, 1, 0, 1, 1, 0, 4'd5, 7'h7F);
        rd(4'd5);
        chk("odd_bwe", o_q, 7'h2A);
        acc(1, 1, 0, 1, 0, 1, 4'd5, 7'h7F);
        rd(4'd5);
        chk("even_bwe", o_q, 7'h7F);

        shift_in({10'h000, mk(1, 2'b01, 4'd2, 3'd0)});
        wr(4'd2, 7'h00);
        rd(4'd2);
        chk("sa1_bit0", o_q, 7'h01);

        shift_in({10'h000, mk(1, 2'b10, 4'd1, 3'd6)});
        wr(4'd1, 7'h00);
        wr(4'd1, 7'h7F);
        rd(4'd1);
        chk("tf_up", o_q, 7'h3F);
        wr(4'd1, 7'h00);
        rd(4'd1);
        chk("tf_up_zero", o_q, 7'h00);

        acc(1, 0, 1, 0, 0, 0, 4'd4, 7'h00);
        chk("oe_low", o_q, 7'h00);
        acc(1, 1, 1, 1, 1, 1, 4'd4, 7'h11);
        chk("rw_hold", o_q, 7'h00);
        rd(4'd4);
        chk("rw_wrote", o_q, 7'h11);

        // Descriptor 1 names bit 7, which does not exist: must be inert.
        shift_in({mk(1, 2'b00, 4'd15, 3'd7), mk(1, 2'b10, 4'd1, 3'd6)});
        chk("so_loaded", {6'b0, so}, 7'h01);
        wr(4'd15, 7'h7F);
        rd(4'd15);
        chk("bit_oob", o_q, 7'h7F);

        // Asynchronous reset in the middle of a read cycle.
        i_cs = 1; i_we = 0; i_re = 1; i_oe = 1; i_addr = 4'd4;
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_o_q", o_q, 7'h00);
        chk("async_rst_so", {6'b0, so}, 7'h00);
        i_we = 1; i_re = 0; i_odd_bwe = 1; i_even_bwe = 1; i_addr = 4'd6; i_data = 7'h7F;
        @(negedge clk);
        rstn = 1'b1;
        rd(4'd6);
        chk("write_in_reset", o_q, 7'h00);
        rd(4'd4);
        chk("kept_after_rst", o_q, 7'h11);
        rd(4'd3);
        chk("kept_55", o_q, 7'h55);
        rd(4'd1);
        chk("desc_cleared", o_q, 7'h00);

        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(0, 2) == 0) begin
                logic [19:0] v;
                v = {mk(1'($urandom), 2'($urandom), 4'($urandom_range(0, 3)), 3'($urandom)),
                     mk(1'($urandom), 2'($urandom), 4'($urandom_range(0, 3)), 3'($urandom))};
                shift_in(v);
            end
            for (int c = 0; c < 40; c++) begin
                logic [3:0] a;
                a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
                acc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                    1'($urandom), 1'($urandom), a, 7'($urandom));
            end
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
